// File: rtl/buffer_mem_responder.sv
//==============================================================================
// Module      : buffer_mem_responder
// Description : Single-port synchronous SRAM buffer with an active-low engine
//               port, a host port for preload/dump, and access counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module buffer_mem_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              mem_cenb_i,
    input  logic              mem_wenb_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    input  logic              host_rready_i,
    output logic              err_o,
    output logic [15:0]       wr_count_o,
    output logic [15:0]       rd_count_o
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_mem_rdata;
    logic [DATA_W-1:0]  r_host_rdata;
    logic               r_err;
    logic [15:0]        r_wr_count;
    logic [15:0]        r_rd_count;

    logic w_eng_wr;
    logic w_eng_rd;
    logic w_eng_inr;
    logic w_host_acc;
    logic w_host_wr;
    logic w_host_rd;
    logic w_host_inr;

    assign w_eng_wr   = ~mem_cenb_i & ~mem_wenb_i;
    assign w_eng_rd   = ~mem_cenb_i &  mem_wenb_i;
    assign w_eng_inr  = ({1'b0, mem_addr_i} < c_DEPTH);
    assign w_host_inr = ({1'b0, host_addr_i} < c_DEPTH);

    // Engine has absolute priority: host is only accepted while the engine is idle
    assign host_ready_o = (r_state == S_IDLE) & mem_cenb_i;
    assign w_host_acc   = host_valid_i & host_ready_o;
    assign w_host_wr    = w_host_acc &  host_we_i;
    assign w_host_rd    = w_host_acc & ~host_we_i;

    // Storage array is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (w_eng_wr && w_eng_inr) begin
            r_mem[mem_addr_i] <= mem_data_i;
        end else if (w_host_wr && w_host_inr) begin
            r_mem[host_addr_i] <= host_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_mem_rdata  <= '0;
            r_host_rdata <= '0;
            r_err        <= 1'b0;
            r_wr_count   <= '0;
            r_rd_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_eng_rd) begin
                r_mem_rdata <= w_eng_inr ? r_mem[mem_addr_i] : '0;
            end
            if (w_host_rd) begin
                r_host_rdata <= w_host_inr ? r_mem[host_addr_i] : '0;
            end
            if ((!mem_cenb_i && !w_eng_inr) || (w_host_acc && !w_host_inr)) begin
                r_err <= 1'b1;
            end
            if (w_eng_wr && r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_eng_rd && r_rd_count != 16'hFFFF) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_host_rd) w_state_nxt = S_RESP;
            S_RESP: if (host_rready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign mem_data_o    = r_mem_rdata;
    assign host_rvalid_o = (r_state == S_RESP);
    assign host_rdata_o  = r_host_rdata;
    assign err_o         = r_err;
    assign wr_count_o    = r_wr_count;
    assign rd_count_o    = r_rd_count;

endmodule

`default_nettype wire
